// File: rtl/operand_fetch.sv
// operand_fetch: decodes an instruction, reads/forwards two operands from a 16x32 RF, holds them for the ALU.
// Define OPERAND_FETCH_ZERO_REG_EN to make register 0 a hardwired zero.
module operand_fetch #(
  parameter int NREGS = 16,
  parameter int XLEN = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [3:0]                 opcode,
  output logic [XLEN-1:0]            reg2,
  output logic [XLEN-1:0]            reg3,
  output logic [$clog2(NREGS)-1:0]   rd,
  input  logic                       wb_en,
  input  logic [$clog2(NREGS)-1:0]   wb_addr,
  input  logic [XLEN-1:0]            wb_data
);
  localparam int AW = $clog2(NREGS);
  logic [XLEN-1:0] rf [NREGS];
  logic [AW-1:0] rs2, rs3, h_rs2, h_rs3;
  logic imm, h_imm, accept, wr_ok;
  logic [XLEN-1:0] rf2, rf3, op2, op3;
  assign rs2 = in_instr[20 +: AW];
  assign rs3 = in_instr[16 +: AW];
  assign imm = in_instr[15];
  assign in_ready = !out_valid || out_ready;
  assign accept = in_valid && in_ready;
`ifdef OPERAND_FETCH_ZERO_REG_EN
  assign wr_ok = wb_en && wb_addr != '0;
  assign rf2 = rs2 == '0 ? '0 : rf[rs2];
  assign rf3 = rs3 == '0 ? '0 : rf[rs3];
`else
  assign wr_ok = wb_en;
  assign rf2 = rf[rs2];
  assign rf3 = rf[rs3];
`endif
  // a write landing in the accept cycle must win over the stale RF copy
  assign op2 = wr_ok && wb_addr == rs2 ? wb_data : rf2;
  assign op3 = imm ? {{(XLEN-15){in_instr[14]}}, in_instr[14:0]} :
               wr_ok && wb_addr == rs3 ? wb_data : rf3;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      out_valid <= 1'b0;
      opcode <= '0;
      reg2 <= '0;
      reg3 <= '0;
      rd <= '0;
      h_rs2 <= '0;
      h_rs3 <= '0;
      h_imm <= 1'b0;
    end else begin
      if (wr_ok) rf[wb_addr] <= wb_data;
      if (accept) begin
        out_valid <= 1'b1;
        opcode <= in_instr[31:28];
        rd <= in_instr[24 +: AW];
        reg2 <= op2;
        reg3 <= op3;
        h_rs2 <= rs2;
        h_rs3 <= rs3;
        h_imm <= imm;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end else if (out_valid && wr_ok) begin
        if (wb_addr == h_rs2) reg2 <= wb_data;
        if (!h_imm && wb_addr == h_rs3) reg3 <= wb_data;
      end
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed vector table, hand sequences, then random traffic against a reference model.
module tb_operand_fetch;
  logic clk = 1'b0, reset, in_valid, out_ready, wb_en;
  logic [31:0] in_instr, wb_data;
  logic [3:0] wb_addr;
  logic in_ready, out_valid;
  logic [3:0] opcode, rd;
  logic [31:0] reg2, reg3;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode), .reg2(reg2), .reg3(reg3),
    .rd(rd), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  typedef struct {
    logic rst, iv, ordy, we, ev, erdy;
    logic [31:0] ins, wd, e2, e3;
    logic [3:0] wa, eop, erd;
  } vec_t;
  vec_t v [15];

  logic [31:0] m_rf [16];
  logic m_valid, m_imm;
  logic [3:0] m_op, m_rd, m_s2, m_s3;
  logic [31:0] m_r2, m_r3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int d, input int s2, input int s3, input int im, input int i15);
    return {op[3:0], d[3:0], s2[3:0], s3[3:0], im[0], i15[14:0]};
  endfunction

  function automatic vec_t row(input int rst, input int iv, input logic [31:0] ins, input int ordy, input int we,
                               input int wa, input logic [31:0] wd, input int ev, input int eop,
                               input logic [31:0] e2, input logic [31:0] e3, input int erd, input int erdy);
    vec_t r;
    r.rst = rst[0]; r.iv = iv[0]; r.ins = ins; r.ordy = ordy[0]; r.we = we[0]; r.wa = wa[3:0]; r.wd = wd;
    r.ev = ev[0]; r.eop = eop[3:0]; r.e2 = e2; r.e3 = e3; r.erd = erd[3:0]; r.erdy = erdy[0];
    return r;
  endfunction

  task automatic drive(input logic rst, input logic iv, input logic [31:0] ins, input logic ordy,
                       input logic we, input logic [3:0] wa, input logic [31:0] wd);
    reset = rst; in_valid = iv; in_instr = ins; out_ready = ordy; wb_en = we; wb_addr = wa; wb_data = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] a);
`ifdef OPERAND_FETCH_ZERO_REG_EN
    if (a == 4'd0) return 32'd0;
`endif
    return m_rf[a];
  endfunction

  // reference: one clock of the stage's documented behaviour, from the current inputs
  task automatic model_step();
    logic wok, acc;
    logic [3:0] s2, s3;
    logic [31:0] v2, v3;
    if (reset) begin
      foreach (m_rf[i]) m_rf[i] = 32'd0;
      m_valid = 0; m_op = 0; m_rd = 0; m_r2 = 0; m_r3 = 0; m_s2 = 0; m_s3 = 0; m_imm = 0;
      return;
    end
    wok = wb_en;
`ifdef OPERAND_FETCH_ZERO_REG_EN
    if (wb_addr == 4'd0) wok = 1'b0;
`endif
    acc = in_valid && (!m_valid || out_ready);
    s2 = in_instr[23:20];
    s3 = in_instr[19:16];
    v2 = (wok && wb_addr == s2) ? wb_data : m_read(s2);
    if (in_instr[15]) v3 = 32'(signed'(in_instr[14:0]));
    else v3 = (wok && wb_addr == s3) ? wb_data : m_read(s3);
    if (acc) begin
      m_valid = 1; m_op = in_instr[31:28]; m_rd = in_instr[27:24];
      m_r2 = v2; m_r3 = v3; m_s2 = s2; m_s3 = s3; m_imm = in_instr[15];
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end else if (m_valid && wok) begin
      if (wb_addr == m_s2) m_r2 = wb_data;
      if (!m_imm && wb_addr == m_s3) m_r3 = wb_data;
    end
    if (wok) m_rf[wb_addr] = wb_data;
  endtask

  initial begin
    v[0]  = row(1, 1, 32'hDEADBEEF, 1, 1, 1, 77, 0, 0, 0, 0, 0, 1);
    v[1]  = row(0, 1, mk(0, 0, 1, 2, 0, 0), 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    v[2]  = row(0, 0, 0, 1, 1, 3, 100, 0, 0, 0, 0, 0, 1);
    v[3]  = row(0, 0, 0, 1, 1, 4, 32'hFFFFFFF9, 0, 0, 0, 0, 0, 1);
    v[4]  = row(0, 1, mk(1, 5, 3, 4, 0, 0), 1, 0, 0, 0, 1, 1, 100, 32'hFFFFFFF9, 5, 1);
    v[5]  = row(0, 1, mk(2, 6, 3, 0, 1, 'h7FFF), 1, 0, 0, 0, 1, 2, 100, 32'hFFFFFFFF, 6, 1);
    v[6]  = row(0, 1, mk(15, 7, 4, 0, 1, 5), 1, 0, 0, 0, 1, 15, 32'hFFFFFFF9, 5, 7, 1);
    v[7]  = row(0, 1, mk(3, 1, 6, 6, 0, 0), 1, 1, 6, 42, 1, 3, 42, 42, 1, 1);
    v[8]  = row(0, 1, mk(4, 2, 6, 0, 1, 'h4000), 1, 0, 0, 0, 1, 4, 42, 32'hFFFFC000, 2, 1);
    v[9]  = row(0, 1, mk(5, 8, 3, 7, 0, 0), 1, 0, 0, 0, 1, 5, 100, 0, 8, 1);
    v[10] = row(0, 1, mk(6, 9, 7, 9, 0, 0), 0, 0, 0, 0, 1, 5, 100, 0, 8, 0);
    v[11] = row(0, 1, mk(6, 9, 7, 9, 0, 0), 0, 1, 7, 9, 1, 5, 100, 9, 8, 0);
    v[12] = row(0, 1, mk(6, 9, 7, 9, 0, 0), 0, 1, 9, 1, 1, 5, 100, 9, 8, 0);
    v[13] = row(0, 1, mk(6, 9, 7, 9, 0, 0), 1, 0, 0, 0, 1, 6, 9, 1, 9, 1);
    v[14] = row(0, 0, 0, 1, 0, 0, 0, 0, 6, 9, 1, 9, 1);

    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 15; i++) begin
      drive(v[i].rst, v[i].iv, v[i].ins, v[i].ordy, v[i].we, v[i].wa, v[i].wd);
      tick();
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(v[i].ev));
      check($sformatf("vec%0d opcode", i), 32'(opcode), 32'(v[i].eop));
      check($sformatf("vec%0d reg2", i), reg2, v[i].e2);
      check($sformatf("vec%0d reg3", i), reg3, v[i].e3);
      check($sformatf("vec%0d rd", i), 32'(rd), 32'(v[i].erd));
      check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(v[i].erdy));
    end

    for (int i = 0; i < 4; i++) begin
      drive(0, 1, mk(i, i + 1, 3, 4, 0, 0), 1, 0, 0, 0);
      tick();
      check($sformatf("stream%0d out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("stream%0d rd", i), 32'(rd), 32'(i + 1));
      check($sformatf("stream%0d reg2", i), reg2, 32'd100);
    end
    drive(1, 1, mk(7, 7, 3, 4, 0, 0), 1, 0, 0, 0);
    tick();
    check("midreset out_valid", 32'(out_valid), 32'd0);
    drive(0, 1, mk(0, 0, 3, 4, 0, 0), 1, 0, 0, 0);
    tick();
    check("post-reset reg2", reg2, 32'd0);
    check("post-reset reg3", reg3, 32'd0);
    drive(0, 0, 0, 1, 1, 0, 55);
    tick();
    drive(0, 1, mk(0, 0, 0, 0, 0, 0), 1, 0, 0, 0);
    tick();
`ifdef OPERAND_FETCH_ZERO_REG_EN
    check("zero reg read", reg2, 32'd0);
`else
    check("reg0 read", reg2, 32'd55);
`endif

    drive(1, 0, 0, 0, 0, 0, 0);
    model_step();
    tick();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins;
      ins = $urandom();
      ins[23:20] = 4'($urandom_range(0, 3));
      ins[19:16] = 4'($urandom_range(0, 3));
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, ins, $urandom_range(0, 2) != 0,
            $urandom_range(0, 1) == 1, 4'($urandom_range(0, 3)), $urandom());
      #1;
      if (!reset) check($sformatf("rand%0d in_ready", i), 32'(in_ready), 32'(!m_valid || out_ready));
      model_step();
      @(posedge clk);
      #1;
      check($sformatf("rand%0d out_valid", i), 32'(out_valid), 32'(m_valid));
      check($sformatf("rand%0d opcode", i), 32'(opcode), 32'(m_op));
      check($sformatf("rand%0d reg2", i), reg2, m_r2);
      check($sformatf("rand%0d reg3", i), reg3, m_r3);
      check($sformatf("rand%0d rd", i), 32'(rd), 32'(m_rd));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Operand-fetch stage sitting directly upstream of the ALU.
- Decodes a 32-bit instruction and reads two source operands from an internal 16x32 register file.
- Presents opcode/reg2/reg3 to the ALU through a one-entry pipeline register with valid/ready handshake.
- Accepts the ALU write_back result into the register file, with same-cycle forwarding.

Parameters:
NREGS, 16, register count; index width = clog2(NREGS) = 4
XLEN, 32, data width of registers and operands

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  instruction present on in_instr
in_ready  output  1  stage can accept instruction this cycle
in_instr  input  32  instruction word
out_valid  output  1  operands valid toward ALU
out_ready  input  1  ALU side accepts current operands
opcode  output  4  ALU opcode
reg2  output  32  signed first operand
reg3  output  32  signed second operand
rd  output  4  destination index, travels with operands
wb_en  input  1  write-back strobe
wb_addr  input  4  write-back register index
wb_data  input  32  write-back value (ALU write_back)

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous, active-high.
- Instruction fields:
  - [31:28] opcode
  - [27:24] rd
  - [23:20] rs2
  - [19:16] rs3
  - [15] imm flag
  - [14:0] imm15
- Operand selection:
  - reg2 = RF[rs2].
  - reg3 = RF[rs3] when imm flag = 0.
  - reg3 = imm15 sign-extended to 32 bits when imm flag = 1.
- Opcode handling: no opcode decoding; all 16 values pass through unchanged, including 1100-1111.
- Reset (reset=1 at edge):
  - All RF entries cleared to 0.
  - out_valid=0; opcode, reg2, reg3, rd = 0.
  - Any held, unconsumed operand set is discarded.
  - wb_en is ignored during the reset cycle.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready: the output register loads the decoded fields and operands, and out_valid=1 next cycle. Latency is 1 cycle from accept to out_valid.
  - Consume when out_valid && out_ready. If there is no simultaneous accept, out_valid=0 next cycle.
  - Simultaneous consume and accept: the output register reloads and out_valid stays 1. Full throughput is one instruction per cycle.
  - While out_valid && !out_ready, the outputs hold stable, except for the refresh rule below.
- Register file write:
  - wb_en=1 writes wb_data to RF[wb_addr] at the edge.
  - Writes happen independently of the handshake.
- Forwarding:
  - On an accept cycle with wb_en=1 and wb_addr==rs2, reg2 is loaded with wb_data, not the stale RF value.
  - Same for rs3 when imm flag = 0.
  - Both operands forward if both indices match.
- Held-operand refresh:
  - Applies while out_valid && !out_ready and wb_en=1.
  - If wb_addr matches the held rs2, reg2 updates to wb_data.
  - Same for held rs3 (non-immediate only). Held source indices and the imm flag are stored internally for this.
- Reads with wb_en=0 return the current RF contents.
- No arithmetic is performed apart from sign extension.

Optional Feature:
- Macro: OPERAND_FETCH_ZERO_REG_EN.
- Defined:
  - RF[0] always reads 0.
  - Writes with wb_addr=0 are dropped.
  - Forwarding and refresh never apply to index 0.
- Undefined: register 0 is a normal read/write register like any other.

Test Plan:
- Reset, then one instruction with rs2=1, rs3=2, imm=0 -> next cycle out_valid=1, reg2=0, reg3=0. During reset the stage shows in_ready=1 and out_valid=0.
- Write RF[3]=100 and RF[4]=-7, then instruction opcode=0001, rd=5, rs2=3, rs3=4, out_ready=1 -> opcode=0001, reg2=100, reg3=-7, rd=5 one cycle after accept.
- Instruction with imm=1, imm15=0x7FFF -> reg3=0xFFFFFFFF. With imm15=0x0005 -> reg3=5.
- Same-cycle forwarding: accept rs2=6 while wb_en=1, wb_addr=6, wb_data=42 -> reg2=42. RF[6]=42 thereafter.
- Stall: out_ready=0 for 3 cycles with a held rs3=7, and wb write RF[7]=9 mid-stall -> in_ready=0 throughout, opcode/rd/reg2 stable, reg3 changes to 9. On out_ready=1 the next instruction is accepted in that same cycle.
- Back-to-back stream of 4 instructions with out_ready=1 -> out_valid stays 1 for 4 consecutive cycles. Assert reset mid-stream -> out_valid=0 next cycle and the RF reads 0. With OPERAND_FETCH_ZERO_REG_EN defined, a write of 55 to register 0 reads back 0.
